// File: rtl/seq6_pkg.sv
// Shared state codes, monitor FSM encoding and sequence helpers for the
// six-state Johnson-style sequence monitor.
package seq6_pkg;

    localparam logic [2:0] S0 = 3'b000;
    localparam logic [2:0] S1 = 3'b001;
    localparam logic [2:0] S2 = 3'b011;
    localparam logic [2:0] S3 = 3'b111;
    localparam logic [2:0] S4 = 3'b110;
    localparam logic [2:0] S5 = 3'b100;

    typedef enum logic [1:0] {
        MON_ACQUIRE = 2'd0,
        MON_TRACK   = 2'd1,
        MON_LOCKED  = 2'd2
    } mon_state_e;

    function automatic logic [2:0] seq6_succ(input logic [2:0] code);
        logic [2:0] nxt;
        case (code)
            S0:      nxt = S1;
            S1:      nxt = S2;
            S2:      nxt = S3;
            S3:      nxt = S4;
            S4:      nxt = S5;
            S5:      nxt = S0;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

    function automatic logic seq6_is_legal(input logic [2:0] code);
        return (code != 3'b010) && (code != 3'b101);
    endfunction

endpackage

// File: rtl/seq6_decode.sv
// Combinational decode of one 3-bit sequence code into legality, successor
// code and one-hot sequence position.
module seq6_decode
    import seq6_pkg::*;
(
    input  logic [2:0] code_i,
    output logic       legal_o,
    output logic [2:0] succ_o,
    output logic [5:0] onehot_o
);

    assign legal_o = seq6_is_legal(code_i);
    assign succ_o  = seq6_succ(code_i);

    // One-hot position within the sequence; illegal codes decode to zero.
    always_comb begin
        case (code_i)
            S0:      onehot_o = 6'b000001;
            S1:      onehot_o = 6'b000010;
            S2:      onehot_o = 6'b000100;
            S3:      onehot_o = 6'b001000;
            S4:      onehot_o = 6'b010000;
            S5:      onehot_o = 6'b100000;
            default: onehot_o = 6'b000000;
        endcase
    end

endmodule

// File: rtl/seq6_monitor.sv
// Sequence monitor for the six-state Johnson-style counter: phase decode,
// illegal-code and order checking, lock tracking and saturating error count.
// Optional feature macro SEQ6_MON_HOLD_EN: treat a stalled count as a legal hold.
module seq6_monitor
    import seq6_pkg::*;
#(
    parameter int LOCK_LEN = 6,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [2:0]       count,
    output logic [5:0]       phase,
    output logic             illegal,
    output logic             locked,
    output logic             seq_err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int               RUN_W   = $clog2(LOCK_LEN + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    mon_state_e       state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [5:0]       phase_q;
    logic             illegal_q, locked_q, seq_err_q, wrap_q;
    logic             seq_err_d, wrap_d;

    logic             cur_legal_s, prev_legal_s;
    logic [2:0]       cur_succ_s, prev_succ_s;
    logic [5:0]       cur_onehot_s, prev_onehot_s;
    logic             match_s, hold_s, unused_s;

    seq6_decode u_dec_cur (
        .code_i   (count),
        .legal_o  (cur_legal_s),
        .succ_o   (cur_succ_s),
        .onehot_o (cur_onehot_s)
    );

    seq6_decode u_dec_prev (
        .code_i   (prev_q),
        .legal_o  (prev_legal_s),
        .succ_o   (prev_succ_s),
        .onehot_o (prev_onehot_s)
    );

    assign match_s  = (count == prev_succ_s);
    assign unused_s = ^{cur_succ_s, prev_legal_s, prev_onehot_s};

`ifdef SEQ6_MON_HOLD_EN
    assign hold_s = (count == prev_q);
`else
    assign hold_s = 1'b0;
`endif

    // Next-state, tracking registers and pulse generation.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        run_d     = run_q;
        seq_err_d = 1'b0;
        wrap_d    = 1'b0;
        case (state_q)
            MON_ACQUIRE: begin
                if (cur_legal_s) begin
                    prev_d  = count;
                    run_d   = RUN_W'(0);
                    state_d = MON_TRACK;
                end else begin
                    state_d = MON_ACQUIRE;
                end
            end
            MON_TRACK: begin
                if (hold_s) begin
                    state_d = MON_TRACK;
                end else if (match_s) begin
                    prev_d = count;
                    run_d  = run_q + RUN_W'(1);
                    if (run_q == RUN_W'(LOCK_LEN - 1)) begin
                        state_d = MON_LOCKED;
                    end else begin
                        state_d = MON_TRACK;
                    end
                end else if (cur_legal_s) begin
                    prev_d = count;
                    run_d  = RUN_W'(0);
                end else begin
                    state_d = MON_ACQUIRE;
                end
            end
            MON_LOCKED: begin
                if (hold_s) begin
                    state_d = MON_LOCKED;
                end else if (match_s) begin
                    prev_d = count;
                    wrap_d = (prev_q == S5) && (count == S0);
                end else begin
                    seq_err_d = 1'b1;
                    run_d     = RUN_W'(0);
                    if (cur_legal_s) begin
                        prev_d  = count;
                        state_d = MON_TRACK;
                    end else begin
                        state_d = MON_ACQUIRE;
                    end
                end
            end
            default: begin
                state_d = MON_ACQUIRE;
            end
        endcase

        if (seq_err_d && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State and output registers; outputs reflect the count sampled this edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= MON_ACQUIRE;
            prev_q    <= S0;
            run_q     <= RUN_W'(0);
            err_cnt_q <= {ERR_W{1'b0}};
            phase_q   <= 6'b000000;
            illegal_q <= 1'b0;
            locked_q  <= 1'b0;
            seq_err_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            run_q     <= run_d;
            err_cnt_q <= err_cnt_d;
            phase_q   <= cur_onehot_s;
            illegal_q <= ~cur_legal_s;
            locked_q  <= (state_d == MON_LOCKED);
            seq_err_q <= seq_err_d;
            wrap_q    <= wrap_d;
        end
    end

    assign phase   = phase_q;
    assign illegal = illegal_q;
    assign locked  = locked_q;
    assign seq_err = seq_err_q;
    assign wrap    = wrap_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_seq6_monitor.sv
// Directed and randomized bench for seq6_monitor; a position-based reference
// model predicts every output, and a second instance checks ERR_W=2 saturation.
module tb_seq6_monitor;

    localparam int LOCK_LEN = 6;
`ifdef SEQ6_MON_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstb;
    logic [2:0] count;
    logic [5:0] phase, phase2;
    logic       illegal, locked, seq_err, wrap;
    logic       illegal2, locked2, seq_err2, wrap2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [2:0] tab [6] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100};

    bit         m_have_ref, m_locked;
    int         m_prev, m_run, m_err;
    logic [5:0] e_phase;
    bit         e_illegal, e_seq_err, e_wrap;
    int         cpos;
    int         wraps;

    seq6_monitor #(.LOCK_LEN(LOCK_LEN), .ERR_W(8)) dut (
        .clk(clk), .rstb(rstb), .count(count), .phase(phase), .illegal(illegal),
        .locked(locked), .seq_err(seq_err), .wrap(wrap), .err_cnt(err_cnt)
    );

    seq6_monitor #(.LOCK_LEN(LOCK_LEN), .ERR_W(2)) dut2 (
        .clk(clk), .rstb(rstb), .count(count), .phase(phase2), .illegal(illegal2),
        .locked(locked2), .seq_err(seq_err2), .wrap(wrap2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    function automatic int pos_of(input logic [2:0] c);
        for (int i = 0; i < 6; i++) begin
            if (tab[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have_ref = 1'b0;
        m_locked   = 1'b0;
        m_prev     = 0;
        m_run      = 0;
        m_err      = 0;
        e_phase    = 6'b000000;
        e_illegal  = 1'b0;
        e_seq_err  = 1'b0;
        e_wrap     = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] c);
        int  p;
        bit  good;
        p         = pos_of(c);
        e_illegal = (p < 0);
        e_phase   = (p >= 0) ? 6'(1 << p) : 6'b000000;
        e_seq_err = 1'b0;
        e_wrap    = 1'b0;
        good      = (p >= 0) && (p == (m_prev + 1) % 6);
        if (!m_have_ref) begin
            if (p >= 0) begin
                m_have_ref = 1'b1;
                m_prev     = p;
                m_run      = 0;
            end
        end else if (HOLD && (p == m_prev)) begin
            m_run = m_run;
        end else if (m_locked) begin
            if (good) begin
                e_wrap = (m_prev == 5);
                m_prev = p;
            end else begin
                e_seq_err = 1'b1;
                m_err++;
                m_run    = 0;
                m_locked = 1'b0;
                if (p < 0) m_have_ref = 1'b0;
                else       m_prev     = p;
            end
        end else if (good) begin
            m_run++;
            m_prev = p;
            if (m_run == LOCK_LEN) m_locked = 1'b1;
        end else if (p >= 0) begin
            m_run  = 0;
            m_prev = p;
        end else begin
            m_have_ref = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".phase"},    phase,    e_phase);
        chk({tag, ".illegal"},  illegal,  e_illegal);
        chk({tag, ".locked"},   locked,   m_locked);
        chk({tag, ".seq_err"},  seq_err,  e_seq_err);
        chk({tag, ".wrap"},     wrap,     e_wrap);
        chk({tag, ".err_cnt"},  err_cnt,  (m_err > 255) ? 255 : m_err);
        chk({tag, ".phase2"},   phase2,   e_phase);
        chk({tag, ".locked2"},  locked2,  m_locked);
        chk({tag, ".seq_err2"}, seq_err2, e_seq_err);
        chk({tag, ".illegal2"}, illegal2, e_illegal);
        chk({tag, ".wrap2"},    wrap2,    e_wrap);
        chk({tag, ".err_cnt2"}, err_cnt2, (m_err > 3) ? 3 : m_err);
    endtask

    task automatic cyc(input logic [2:0] c, input string tag);
        @(negedge clk);
        count = c;
        model_step(c);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic adv(input string tag);
        cpos = (cpos + 1) % 6;
        cyc(tab[cpos], tag);
    endtask

    initial begin
        rstb  = 1'b0;
        count = 3'b101;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rstb = 1'b1;

        // 1: reset code absorbed, then lock on the second 000
        cyc(3'b101, "t1_rst_code");
        cpos = 0;
        cyc(tab[0], "t1_first");
        repeat (6) adv("t1_seq");
        chk("t1_locked", locked, 1);

        // 2: skip while locked, then relock
        adv("t2_pre");
        cpos = (cpos + 2) % 6;
        cyc(tab[cpos], "t2_skip");
        chk("t2_err_cnt", err_cnt, 1);
        chk("t2_unlocked", locked, 0);
        repeat (6) adv("t2_relock");
        chk("t2_locked", locked, 1);

        // 3: illegal code while locked, then reacquire
        while (cpos != 2) adv("t3_pre");
        cyc(3'b010, "t3_illegal");
        chk("t3_seq_err", seq_err, 1);
        chk("t3_phase", phase, 0);
        cpos = 0;
        cyc(tab[0], "t3_reacq");
        repeat (6) adv("t3_relock");

        // 4: repeated lock/skip drives the narrow counter into saturation
        for (int k = 0; k < 5; k++) begin
            cpos = (cpos + 2) % 6;
            cyc(tab[cpos], "t4_skip");
            repeat (6) adv("t4_relock");
        end
        chk("t4_sat", err_cnt2, 3);

        // 5: stalled counter while locked
        adv("t5_pre");
        cyc(tab[cpos], "t5_hold");
        repeat (6) adv("t5_after");

        // 6: asynchronous reset mid-cycle, relock and count wraps
        @(posedge clk);
        #3;
        rstb = 1'b0;
        #1;
        chk("t6_async_phase", phase, 0);
        chk("t6_async_locked", locked, 0);
        chk("t6_async_err", err_cnt, 0);
        model_reset();
        count = 3'b101;
        @(posedge clk);
        #1;
        check_all("t6_in_reset");
        rstb = 1'b1;
        cyc(3'b101, "t6_rst_code");
        cpos = 0;
        cyc(tab[0], "t6_first");
        repeat (6) adv("t6_lock");
        wraps = 0;
        for (int k = 0; k < 12; k++) begin
            adv("t6_run");
            wraps += int'(wrap);
        end
        chk("t6_wraps", wraps, 2);

        // Randomized: mostly in-order with stalls, skips and illegal codes
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 85) begin
                adv("rnd_step");
            end else if (r < 92) begin
                cyc(tab[cpos], "rnd_hold");
            end else begin
                logic [2:0] c;
                c = 3'($urandom_range(0, 7));
                if (pos_of(c) >= 0) cpos = pos_of(c);
                cyc(c, "rnd_any");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
